// File: rtl/icache_refill_ctrl.sv
// Direct-mapped instruction cache with a single-outstanding burst refill engine.
// Addresses with [31:29] == 3'b101 bypass the array and are fetched as single beats.
module icache_refill_ctrl #(
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 3
) (
  input  logic        clk,
  input  logic        rset,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        inv_all,
  output logic [31:0] i_addr,
  output logic        i_addr_valid,
  output logic        i_we,
  output logic [2:0]  i_size,
  output logic [7:0]  i_lens,
  output logic        i_rready,
  input  logic        i_valid_clear,
  input  logic        i_rd_dready,
  input  logic [31:0] i_rd_data,
  input  logic        i_rlast
);

  localparam int TAG_W = 32 - INDEX_W - OFFSET_W - 2;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << (INDEX_W + OFFSET_W);
  localparam logic [7:0] LINE_LENS = 8'((1 << OFFSET_W) - 1);

  typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

  state_t              state;
  logic [31:0]         data_mem [WORDS];
  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [LINES-1:0]    valid;
  logic [31:2]         addr_q;
  logic [31:0]         hold_q;
  logic [OFFSET_W-1:0] beat_q;
  logic                unc_q;
  logic                inv_pend_q;

  logic [OFFSET_W-1:0] in_off, q_off;
  logic [INDEX_W-1:0]  in_idx, q_idx;
  logic [TAG_W-1:0]    in_tag, q_tag;
  logic                in_unc, hit;

  assign in_off = cpu_addr[OFFSET_W+1:2];
  assign in_idx = cpu_addr[OFFSET_W+2 +: INDEX_W];
  assign in_tag = cpu_addr[31 -: TAG_W];
  assign q_off  = addr_q[OFFSET_W+1:2];
  assign q_idx  = addr_q[OFFSET_W+2 +: INDEX_W];
  assign q_tag  = addr_q[31 -: TAG_W];
  assign in_unc = (cpu_addr[31:29] == 3'b101);
  assign hit    = cpu_req && !in_unc && valid[in_idx] && (tag_mem[in_idx] == in_tag);

  assign i_we   = 1'b0;
  assign i_size = 3'b010;

  // CPU-side outputs are combinational so a hit is served with zero latency.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    cpu_rdata = '0;
    cpu_stall = 1'b0;
    if (!rset) begin
      unique case (state)
        IDLE: if (cpu_req) begin
          cpu_stall = !hit;
          if (hit) cpu_rdata = data_mem[{in_idx, in_off}];
        end
        REQ, FILL: cpu_stall = 1'b1;
        DONE: cpu_rdata = unc_q ? hold_q : data_mem[{q_idx, q_off}];
      endcase
    end
  end

  // NOTE: data and tag arrays carry no reset; the valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (state == FILL && i_rd_dready && !unc_q) begin
      data_mem[{q_idx, beat_q}] <= i_rd_data;
      if (i_rlast) tag_mem[q_idx] <= q_tag;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge clk or posedge rset) begin
    if (rset) begin
      state        <= IDLE;
      valid        <= '0;
      beat_q       <= '0;
      addr_q       <= '0;
      hold_q       <= '0;
      unc_q        <= 1'b0;
      inv_pend_q   <= 1'b0;
      i_addr_valid <= 1'b0;
      i_rready     <= 1'b0;
      i_addr       <= '0;
      i_lens       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (inv_all) valid <= '0;
          if (cpu_req && !hit) begin
            addr_q       <= cpu_addr[31:2];
            unc_q        <= in_unc;
            beat_q       <= '0;
            inv_pend_q   <= 1'b0;
            i_addr_valid <= 1'b1;
            i_addr       <= in_unc ? cpu_addr
                                   : {cpu_addr[31:OFFSET_W+2], {(OFFSET_W+2){1'b0}}};
            i_lens       <= in_unc ? 8'd0 : LINE_LENS;
            state        <= REQ;
          end
        end
        REQ: begin
          if (inv_all) inv_pend_q <= 1'b1;
          if (i_valid_clear) begin
            i_addr_valid <= 1'b0;
            i_rready     <= 1'b1;
            state        <= FILL;
          end
        end
        FILL: begin
          if (inv_all) inv_pend_q <= 1'b1;
          if (i_rd_dready) begin
            // Counter wraps at the line size, so an over-long burst overwrites in place.
            beat_q <= beat_q + 1'b1;
            if (unc_q) hold_q <= i_rd_data;
            if (i_rlast) begin
              if (!unc_q) valid[q_idx] <= 1'b1;
              i_rready <= 1'b0;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          if (inv_pend_q || inv_all) valid <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: scripted bus transactions plus a
// table of lookup probes with hand-computed hit/miss and data expectations.
module tb_icache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rset;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        inv_all;
  logic [31:0] i_addr;
  logic        i_addr_valid;
  logic        i_we;
  logic [2:0]  i_size;
  logic [7:0]  i_lens;
  logic        i_rready;
  logic        i_valid_clear;
  logic        i_rd_dready;
  logic [31:0] i_rd_data;
  logic        i_rlast;

  int n_checks = 0;
  int n_errors = 0;
  int req_count = 0;
  logic av_prev = 1'b0;

  icache_refill_ctrl #(.INDEX_W(6), .OFFSET_W(3)) dut (
    .clk(clk), .rset(rset), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .inv_all(inv_all),
    .i_addr(i_addr), .i_addr_valid(i_addr_valid), .i_we(i_we), .i_size(i_size),
    .i_lens(i_lens), .i_rready(i_rready), .i_valid_clear(i_valid_clear),
    .i_rd_dready(i_rd_dready), .i_rd_data(i_rd_data), .i_rlast(i_rlast)
  );

  always #5 clk = ~clk;

  // Counts bus requests as rising edges of i_addr_valid.
  always @(negedge clk) begin
    if (i_addr_valid && !av_prev) req_count++;
    av_prev = i_addr_valid;
  end

  typedef struct {
    logic [31:0] addr;
    logic        exp_hit;
    logic [31:0] exp_data;
  } probe_t;

  probe_t probes [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Lookup only: request is dropped before the edge so a miss never starts a refill.
  task automatic probe(input logic [31:0] addr, input logic exp_hit, input logic [31:0] exp_data);
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_addr = addr;
    #1;
    check($sformatf("probe_stall_%h", addr), cpu_stall, !exp_hit);
    if (exp_hit) check($sformatf("probe_data_%h", addr), cpu_rdata, exp_data);
    #1 cpu_req = 1'b0;
  endtask

  task automatic miss_txn(input logic [31:0] addr, input int nbeats, input logic [31:0] dbase,
                          input int delay, input logic inv_in_fill, input logic [31:0] exp_rdata);
    logic        unc;
    logic [31:0] exp_addr;
    unc      = (addr[31:29] == 3'b101);
    exp_addr = unc ? addr : {addr[31:5], 5'b0};
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_addr = addr;
    #1 check("miss_stall", cpu_stall, 1'b1);
    @(negedge clk);
    cpu_req  = 1'b0;
    cpu_addr = 32'h0000_1F00;  // must be ignored while the refill is active
    check("req_addr_valid", i_addr_valid, 1'b1);
    check("req_addr", i_addr, exp_addr);
    check("req_lens", {24'b0, i_lens}, unc ? 32'd0 : 32'd7);
    check("req_stall", cpu_stall, 1'b1);
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      check("addr_valid_held", i_addr_valid, 1'b1);
    end
    i_valid_clear = 1'b1;
    @(negedge clk);
    i_valid_clear = 1'b0;
    check("fill_addr_valid_low", i_addr_valid, 1'b0);
    check("fill_rready", i_rready, 1'b1);
    for (int b = 0; b < nbeats; b++) begin
      i_rd_dready = 1'b1;
      i_rd_data   = dbase + 32'(b);
      i_rlast     = (b == nbeats - 1);
      inv_all     = inv_in_fill && (b == 1);
      @(negedge clk);
      check("fill_stall", cpu_stall, (b == nbeats - 1) ? 1'b0 : 1'b1);
    end
    i_rd_dready = 1'b0;
    i_rlast     = 1'b0;
    inv_all     = 1'b0;
    check("done_rdata", cpu_rdata, exp_rdata);
    check("done_rready_low", i_rready, 1'b0);
    @(negedge clk);
    check("idle_stall", cpu_stall, 1'b0);
    check("idle_no_bus", i_addr_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_count;
    rset = 1'b1; cpu_req = 1'b0; cpu_addr = '0; inv_all = 1'b0;
    i_valid_clear = 1'b0; i_rd_dready = 1'b0; i_rd_data = '0; i_rlast = 1'b0;
    #12;
    check("rst_stall", cpu_stall, 1'b0);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_addr_valid", i_addr_valid, 1'b0);
    check("rst_rready", i_rready, 1'b0);
    check("rst_addr", i_addr, 32'h0);
    check("rst_lens", {24'b0, i_lens}, 32'h0);
    check("const_we", i_we, 1'b0);
    check("const_size", {29'b0, i_size}, 32'h2);
    @(negedge clk) rset = 1'b0;

    miss_txn(32'h0000_1024, 8, 32'hA0, 0, 1'b0, 32'hA1);
    miss_txn(32'hA000_0010, 1, 32'h1234, 0, 1'b0, 32'h1234);
    miss_txn(32'h0000_1000, 8, 32'hC0, 0, 1'b0, 32'hC0);
    base_count = req_count;
    miss_txn(32'h0000_1800, 8, 32'hD0, 5, 1'b0, 32'hD0);
    check("single_request", 32'(req_count - base_count), 32'd1);
    // 10 beats into an 8-word line: words 0 and 1 are overwritten by beats 8 and 9.
    miss_txn(32'h0000_1044, 10, 32'hB0, 0, 1'b0, 32'hB9);

    probes[0]  = '{32'h0000_1020, 1'b1, 32'hA0};
    probes[1]  = '{32'h0000_1024, 1'b1, 32'hA1};
    probes[2]  = '{32'h0000_103C, 1'b1, 32'hA7};
    probes[3]  = '{32'h0000_2020, 1'b0, 32'h0};
    probes[4]  = '{32'hA000_0010, 1'b0, 32'h0};
    probes[5]  = '{32'h0000_1000, 1'b0, 32'h0};
    probes[6]  = '{32'h0000_1800, 1'b1, 32'hD0};
    probes[7]  = '{32'h0000_181C, 1'b1, 32'hD7};
    probes[8]  = '{32'h0000_1040, 1'b1, 32'hB8};
    probes[9]  = '{32'h0000_1048, 1'b1, 32'hB2};
    probes[10] = '{32'h0000_1044, 1'b1, 32'hB9};
    probes[11] = '{32'h0000_105C, 1'b1, 32'hB7};
    for (int i = 0; i < 12; i++) probe(probes[i].addr, probes[i].exp_hit, probes[i].exp_data);

    // Invalidate during fill: word still returned, then every line is gone.
    miss_txn(32'h0000_1064, 8, 32'hE0, 0, 1'b1, 32'hE1);
    probe(32'h0000_1064, 1'b0, 32'h0);
    probe(32'h0000_1020, 1'b0, 32'h0);

    // Invalidate in IDLE: same-cycle lookup still hits, the next one misses.
    miss_txn(32'h0000_1020, 8, 32'hA0, 0, 1'b0, 32'hA0);
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 32'h0000_1024; inv_all = 1'b1;
    #1;
    check("inv_idle_hit_stall", cpu_stall, 1'b0);
    check("inv_idle_hit_data", cpu_rdata, 32'hA1);
    @(negedge clk);
    inv_all = 1'b0;
    check("inv_idle_no_bus", i_addr_valid, 1'b0);
    #1 check("inv_idle_then_miss", cpu_stall, 1'b1);
    cpu_req = 1'b0;

    // Reset in the middle of a fill after three beats.
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 32'h0000_30A0;
    @(negedge clk);
    check("rstmid_req", i_addr_valid, 1'b1);
    i_valid_clear = 1'b1;
    @(negedge clk);
    i_valid_clear = 1'b0;
    for (int b = 0; b < 3; b++) begin
      i_rd_dready = 1'b1; i_rd_data = 32'hF0 + 32'(b);
      @(negedge clk);
    end
    rset = 1'b1;
    #1;
    check("rstmid_stall", cpu_stall, 1'b0);
    check("rstmid_rdata", cpu_rdata, 32'h0);
    check("rstmid_rready", i_rready, 1'b0);
    check("rstmid_addr_valid", i_addr_valid, 1'b0);
    check("rstmid_addr", i_addr, 32'h0);
    check("rstmid_lens", {24'b0, i_lens}, 32'h0);
    @(negedge clk);
    rset = 1'b0; cpu_req = 1'b0;
    i_rlast = 1'b1;
    @(negedge clk);
    check("stray_beat_rready", i_rready, 1'b0);
    check("stray_beat_no_bus", i_addr_valid, 1'b0);
    check("stray_beat_stall", cpu_stall, 1'b0);
    i_rd_dready = 1'b0; i_rlast = 1'b0;
    probe(32'h0000_30A0, 1'b0, 32'h0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 SHALL have parameter INDEX_W, default 6, line-index width (2^INDEX_W lines).
REQ-002 SHALL have parameter OFFSET_W, default 3, word-offset width (2^OFFSET_W words per line).
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 rset  input  1  asynchronous, active-high reset.
REQ-005 cpu_req  input  1  fetch request valid.
REQ-006 cpu_addr  input  32  fetch byte address, word aligned.
REQ-007 cpu_rdata  output  32  fetched instruction.
REQ-008 cpu_stall  output  1  high while the request is not yet served.
REQ-009 inv_all  input  1  invalidate all lines (fence.i).
REQ-010 i_addr  output  32  bus read address.
REQ-011 i_addr_valid  output  1  bus read request.
REQ-012 i_we  output  1  constant 0.
REQ-013 i_size  output  3  constant 3'b010.
REQ-014 i_lens  output  8  burst length minus one.
REQ-015 i_rready  output  1  ready to accept read beats.
REQ-016 i_valid_clear  input  1  one-cycle pulse: bus accepted read address.
REQ-017 i_rd_dready  input  1  read beat valid this cycle.
REQ-018 i_rd_data  input  32  read beat data.
REQ-019 i_rlast  input  1  final beat of burst.

Function
REQ-020 Direct-mapped cache: offset=cpu_addr[OFFSET_W+1:2], index=next INDEX_W bits, tag=remaining upper bits; per line a valid bit, tag, 2^OFFSET_W words.
REQ-021 Uncached: cpu_addr[31:29]==3'b101 SHALL bypass the array; all other addresses cached.
REQ-022 States: IDLE, REQ, FILL, DONE.
REQ-023 IDLE, cpu_req, cached, valid && tag match: hit; cpu_rdata=word combinationally, cpu_stall=0, zero-cycle latency, state unchanged.
REQ-024 IDLE, cpu_req, miss or uncached: cpu_stall=1 same cycle; latch address; go to REQ next cycle.
REQ-025 REQ: i_addr_valid=1; cached miss -> i_addr={addr[31:OFFSET_W+2],zeros}, i_lens=2^OFFSET_W-1; uncached -> i_addr=latched address, i_lens=0.
REQ-026 REQ: on i_valid_clear, i_addr_valid SHALL drop the next cycle and state moves to FILL; i_addr_valid never reasserts within one transaction.
REQ-027 FILL: i_rready=1; each i_rd_dready beat written to word at internal beat counter (starting 0, +1 per beat); uncached beat captured into a holding register only.
REQ-028 FILL, i_rd_dready && i_rlast: cached -> set valid and tag of the line; go to DONE.
REQ-029 Beats beyond 2^OFFSET_W before i_rlast SHALL wrap the counter and overwrite (no array overflow).
REQ-030 DONE: cpu_rdata=requested word (array or holding register), cpu_stall=0 for exactly one cycle; return to IDLE.
REQ-031 cpu_stall=1 throughout REQ and FILL.
REQ-032 cpu_addr changes during REQ/FILL SHALL be ignored; the latched address governs.
REQ-033 inv_all in IDLE: clear all valid bits next edge; a same-cycle lookup uses pre-clear state.
REQ-034 inv_all during REQ/FILL/DONE: clear all valid bits at end of transaction (DONE->IDLE edge), overriding the fill's valid set; the requested word is still returned.
REQ-035 i_rd_dready outside FILL SHALL be ignored.
REQ-036 cpu_req low in IDLE: cpu_stall=0, no bus activity.

Reset
REQ-037 rset asserted: state=IDLE, all valid bits=0, beat counter=0, i_addr_valid=0, i_rready=0, cpu_stall=0, cpu_rdata=0, i_addr=0, i_lens=0; data/tag arrays not reset.
REQ-038 rset mid-transaction: abort immediately; later bus beats ignored per REQ-035.

Verification
REQ-039 Cold miss cpu_addr=0x00001024 -> i_addr=0x00001020, i_lens=7; 8 beats 0xA0..0xA7 -> DONE returns 0xA1; repeat fetch hits with cpu_stall=0.
REQ-040 Uncached cpu_addr=0xA0000010 -> i_addr=0xA0000010, i_lens=0; 1 beat 0x1234 -> cpu_rdata=0x1234; refetch misses again.
REQ-041 Conflict: fill 0x00001000 then 0x00001800 (same index) -> 0x00001000 misses again.
REQ-042 i_valid_clear delayed 5 cycles -> i_addr_valid held exactly until then, single request issued.
REQ-043 inv_all pulse during FILL -> word returned, subsequent fetch of same line misses.
REQ-044 rset asserted mid-FILL after 3 beats -> outputs at reset values immediately; line stays invalid.
